mbc1_bus_sched: RTL

- Synchronous cartridge-bus scheduler placed in front of an MBC1-style bank mapper.
- Shares the single cartridge bus between two requesters: port 0 is the host CPU side, port 1 is the loader/debug side.
- Sequences each access as SETUP / STROBE / HOLD phases and keeps shadow copies of the mapper bank registers.
- Blocks external-RAM accesses while the shadow RAM-enable is clear.

---
 rtl/mbc1_bus_sched_if.sv | 51 +++++
 rtl/mbc1_bus_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mbc1_bus_sched_if.sv
// Bundle of requester handshakes, cartridge bus pins and shadow-register outputs
// for mbc1_bus_sched; master = requesters/cartridge side, slave = scheduler.
interface mbc1_bus_sched_if;
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic        gnt0;
    logic        done0;

    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        gnt1;
    logic        done1;

    logic [7:0]  rdata;

    logic [15:0] cart_a;
    logic [7:0]  cart_dout;
    logic        cart_doe;
    logic [7:0]  cart_din;
    logic        cart_rd_n;
    logic        cart_wr_n;
    logic        cart_cs_n;

    logic        sh_ramen;
    logic [4:0]  sh_bank1;
    logic [1:0]  sh_bank2;
    logic        sh_mode;
    logic        busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output cart_din,
        input  gnt0, done0, gnt1, done1, rdata,
        input  cart_a, cart_dout, cart_doe, cart_rd_n, cart_wr_n, cart_cs_n,
        input  sh_ramen, sh_bank1, sh_bank2, sh_mode, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  cart_din,
        output gnt0, done0, gnt1, done1, rdata,
        output cart_a, cart_dout, cart_doe, cart_rd_n, cart_wr_n, cart_cs_n,
        output sh_ramen, sh_bank1, sh_bank2, sh_mode, busy
    );
endinterface

// File: rtl/mbc1_bus_sched.sv
// Two-port cartridge bus scheduler with SETUP/STROBE/HOLD sequencing and MBC1 shadow registers.
// Define MBC1_RR_ARB_EN for round-robin tie-break; default build uses fixed priority (port 0).
module mbc1_bus_sched #(
    parameter int STROBE_CYCLES = 2
) (
    input logic             ck,
    input logic             nres,
    mbc1_bus_sched_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [3:0] LP_STROBE_LAST = 4'(STROBE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_port;
    logic        r_we;
    logic        r_blocked;
    logic        r_blk_pend;
    logic        r_last_grant;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic [7:0]  r_rdata;

    logic [15:0] r_cart_a;
    logic [7:0]  r_cart_dout;
    logic        r_cart_doe;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_cs_n;

    logic        r_sh_ramen;
    logic [4:0]  r_sh_bank1;
    logic [1:0]  r_sh_bank2;
    logic        r_sh_mode;

    logic        w_any_req;
    logic        w_pick1;
    logic [15:0] w_win_addr;
    logic        w_win_we;
    logic [7:0]  w_win_wdata;
    logic        w_win_ram;
    logic        w_win_blocked;

    // Winner selection; only the tie-break differs between the two builds.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
`ifdef MBC1_RR_ARB_EN
        w_pick1   = bus.req1 & (~bus.req0 | ~r_last_grant);
`else
        w_pick1   = bus.req1 & ~bus.req0;
`endif
        w_win_addr    = w_pick1 ? bus.addr1  : bus.addr0;
        w_win_we      = w_pick1 ? bus.we1    : bus.we0;
        w_win_wdata   = w_pick1 ? bus.wdata1 : bus.wdata0;
        w_win_ram     = (w_win_addr[15:13] == 3'b101);
        w_win_blocked = w_win_ram & ~r_sh_ramen;
    end

    // cart_a and cart_dout double as the latched address/data of the current access.
    always_ff @(posedge ck) begin
        if (!nres) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_blocked    <= 1'b0;
            r_blk_pend   <= 1'b0;
            r_last_grant <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata      <= 8'h00;
            r_cart_a     <= 16'h0000;
            r_cart_dout  <= 8'h00;
            r_cart_doe   <= 1'b0;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_cs_n       <= 1'b1;
            r_sh_ramen   <= 1'b0;
            r_sh_bank1   <= 5'd0;
            r_sh_bank2   <= 2'd0;
            r_sh_mode    <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port       <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_we         <= w_win_we;
                        r_gnt0       <= ~w_pick1;
                        r_gnt1       <= w_pick1;
                        r_cart_a     <= w_win_addr;
                        r_cart_dout  <= w_win_wdata;
                        if (w_win_blocked) begin
                            r_state    <= ST_HOLD;
                            r_blocked  <= 1'b1;
                            r_blk_pend <= 1'b1;
                        end else begin
                            r_state    <= ST_SETUP;
                            r_blocked  <= 1'b0;
                            r_cart_doe <= w_win_we;
                            r_cs_n     <= ~w_win_ram;
                        end
                    end
                end
                ST_SETUP: begin
                    r_rd_n  <= r_we;
                    r_wr_n  <= ~r_we;
                    r_cnt   <= LP_STROBE_LAST;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_rd_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                        r_done0 <= ~r_port;
                        r_done1 <= r_port;
                        if (!r_we) begin
                            r_rdata <= bus.cart_din;
                        end
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    // A blocked access spends an extra HOLD cycle so its done lands one cycle after gnt.
                    if (r_blk_pend) begin
                        r_blk_pend <= 1'b0;
                        r_done0    <= ~r_port;
                        r_done1    <= r_port;
                        if (!r_we) begin
                            r_rdata <= 8'hFF;
                        end
                    end else begin
                        r_state    <= ST_IDLE;
                        r_cs_n     <= 1'b1;
                        r_cart_doe <= 1'b0;
                        if (r_we && !r_blocked) begin
                            case (r_cart_a[15:13])
                                3'b000:  r_sh_ramen <= (r_cart_dout[3:0] == 4'hA);
                                3'b001:  r_sh_bank1 <= r_cart_dout[4:0];
                                3'b010:  r_sh_bank2 <= r_cart_dout[1:0];
                                3'b011:  r_sh_mode  <= r_cart_dout[0];
                                default: ;
                            endcase
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rdata     = r_rdata;
    assign bus.cart_a    = r_cart_a;
    assign bus.cart_dout = r_cart_dout;
    assign bus.cart_doe  = r_cart_doe;
    assign bus.cart_rd_n = r_rd_n;
    assign bus.cart_wr_n = r_wr_n;
    assign bus.cart_cs_n = r_cs_n;
    assign bus.sh_ramen  = r_sh_ramen;
    assign bus.sh_bank1  = r_sh_bank1;
    assign bus.sh_bank2  = r_sh_bank2;
    assign bus.sh_mode   = r_sh_mode;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
